// File: rtl/req_dispatcher_4slv.sv
// Master-side request dispatcher: decodes the slave from the top address bits,
// buffers requests in a 2-entry in-order FIFO, and pushes read tags to the sequencer.
module req_dispatcher_4slv #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m_req_i,
  input  logic                  m_we_i,
  input  logic [ADDR_WIDTH-1:0] m_addr_bi,
  input  logic [DATA_WIDTH-1:0] m_wdata_bi,
  output logic                  m_ack_o,
  input  logic                  tag_fifo_full_i,
  output logic                  tag_fifo_wrreq_o,
  output logic [TAG_WIDTH-1:0]  tag_fifo_wdata_bo,
  output logic                  s0_req_o,
  output logic                  s0_we_o,
  output logic [ADDR_WIDTH-1:0] s0_addr_bo,
  output logic [DATA_WIDTH-1:0] s0_wdata_bo,
  input  logic                  s0_ack_i,
  output logic                  s1_req_o,
  output logic                  s1_we_o,
  output logic [ADDR_WIDTH-1:0] s1_addr_bo,
  output logic [DATA_WIDTH-1:0] s1_wdata_bo,
  input  logic                  s1_ack_i,
  output logic                  s2_req_o,
  output logic                  s2_we_o,
  output logic [ADDR_WIDTH-1:0] s2_addr_bo,
  output logic [DATA_WIDTH-1:0] s2_wdata_bo,
  input  logic                  s2_ack_i,
  output logic                  s3_req_o,
  output logic                  s3_we_o,
  output logic [ADDR_WIDTH-1:0] s3_addr_bo,
  output logic [DATA_WIDTH-1:0] s3_wdata_bo,
  input  logic                  s3_ack_i
);

  logic                  ent_we    [2];
  logic [ADDR_WIDTH-1:0] ent_addr  [2];
  logic [DATA_WIDTH-1:0] ent_wdata [2];
  logic [1:0]            ent_sel   [2];

  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;

  logic [1:0] m_sel;
  logic       accept;
  logic       pop;
  logic       h_we;
  logic [ADDR_WIDTH-1:0] h_addr;
  logic [DATA_WIDTH-1:0] h_wdata;
  logic [1:0] h_sel;
  logic [3:0] slv_req;
  logic [3:0] slv_ack;

  assign m_sel   = m_addr_bi[ADDR_WIDTH-1:ADDR_WIDTH-2];
  assign h_we    = ent_we[rd_ptr];
  assign h_addr  = ent_addr[rd_ptr];
  assign h_wdata = ent_wdata[rd_ptr];
  assign h_sel   = ent_sel[rd_ptr];
  assign slv_ack = {s3_ack_i, s2_ack_i, s1_ack_i, s0_ack_i};

  // Full buffer refuses even when the head pops this cycle (no fall-through).
  assign accept  = m_req_i && (count < 2'd2) && (m_we_i || !tag_fifo_full_i);
  assign pop     = (count != 2'd0) && slv_ack[h_sel];
  assign m_ack_o = accept;
  assign tag_fifo_wrreq_o = accept && !m_we_i;

  always_comb begin
    tag_fifo_wdata_bo = '0;
    if (tag_fifo_wrreq_o) tag_fifo_wdata_bo[1:0] = m_sel;
  end

  assign slv_req = (count != 2'd0) ? (4'b0001 << h_sel) : 4'b0000;

  assign s0_req_o    = slv_req[0];
  assign s0_we_o     = slv_req[0] & h_we;
  assign s0_addr_bo  = slv_req[0] ? h_addr  : '0;
  assign s0_wdata_bo = slv_req[0] ? h_wdata : '0;
  assign s1_req_o    = slv_req[1];
  assign s1_we_o     = slv_req[1] & h_we;
  assign s1_addr_bo  = slv_req[1] ? h_addr  : '0;
  assign s1_wdata_bo = slv_req[1] ? h_wdata : '0;
  assign s2_req_o    = slv_req[2];
  assign s2_we_o     = slv_req[2] & h_we;
  assign s2_addr_bo  = slv_req[2] ? h_addr  : '0;
  assign s2_wdata_bo = slv_req[2] ? h_wdata : '0;
  assign s3_req_o    = slv_req[3];
  assign s3_we_o     = slv_req[3] & h_we;
  assign s3_addr_bo  = slv_req[3] ? h_addr  : '0;
  assign s3_wdata_bo = slv_req[3] ? h_wdata : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        ent_we[i]    <= 1'b0;
        ent_addr[i]  <= '0;
        ent_wdata[i] <= '0;
        ent_sel[i]   <= '0;
      end
    end else begin
      if (accept) begin
        ent_we[wr_ptr]    <= m_we_i;
        ent_addr[wr_ptr]  <= m_addr_bi;
        ent_wdata[wr_ptr] <= m_wdata_bi;
        ent_sel[wr_ptr]   <= m_sel;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/req_dispatcher_4slv.md
Name: req_dispatcher_4slv

Overview:
- Master-side request dispatcher that sits directly upstream of the 4-writer, 8-entry response sequencer in the crossbar.
- Accepts master requests, decodes the target slave from the top two address bits, and buffers requests in a 2-entry in-order FIFO.
- Issues buffered requests to one of 4 slave ports using a req/ack handshake.
- For every accepted read, pushes the slave index into the sequencer's tag FIFO in acceptance order, so read responses can be reordered back into request order.

Parameters:
- ADDR_WIDTH, 32, address width; bits [ADDR_WIDTH-1:ADDR_WIDTH-2] select the slave.
- DATA_WIDTH, 32, write data width.
- TAG_WIDTH, 2, tag width; must be >= 2; tag value = slave index, zero-extended.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- m_req_i  in  1  master request valid
- m_we_i  in  1  1 = write, 0 = read
- m_addr_bi  in  ADDR_WIDTH  request address
- m_wdata_bi  in  DATA_WIDTH  write data
- m_ack_o  out  1  request accepted this cycle (combinational)
- tag_fifo_full_i  in  1  sequencer tag FIFO full
- tag_fifo_wrreq_o  out  1  push tag (combinational)
- tag_fifo_wdata_bo  out  TAG_WIDTH  tag to push
- sK_req_o  out  1  slave K request, K = 0..3
- sK_we_o  out  1  slave K write enable
- sK_addr_bo  out  ADDR_WIDTH  slave K address (full address passed through)
- sK_wdata_bo  out  DATA_WIDTH  slave K write data
- sK_ack_i  in  1  slave K accepted request

Behaviour:
- Interface (already decided): one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset: 2-entry buffer emptied (count = 0, pointers = 0). All sK_req_o = 0. m_ack_o, tag_fifo_wrreq_o = 0 while the buffer is empty and no request is present. Entry contents are cleared to 0.
- Acceptance: m_ack_o = m_req_i && (count < 2) && (m_we_i || !tag_fifo_full_i).
  - No accept when count == 2, even if the head is popped in the same cycle.
- Tag push: tag_fifo_wrreq_o = m_ack_o && !m_we_i; tag_fifo_wdata_bo = m_addr_bi[ADDR_WIDTH-1:ADDR_WIDTH-2].
  - Writes never push a tag.
  - tag_fifo_wdata_bo = 0 when tag_fifo_wrreq_o = 0.
- On accept: {we, addr, wdata, sel} is written to the tail entry at the clock edge.
- Issue:
  - Head entry drives only slave sel: sK_req_o = (count > 0) && (head.sel == K).
  - sK_we_o, sK_addr_bo, sK_wdata_bo carry head fields when sK_req_o = 1, else 0.
  - Fields are held stable until ack.
- Pop: head is popped at the edge where s[head.sel]_ack_i = 1 and count > 0.
  - Acks from non-selected slaves, or any ack while count == 0, are ignored.
- Latency: a request accepted in cycle N appears on its slave port in cycle N+1 at the earliest. Ack in cycle M releases the slot and presents the next head in cycle M+1.
- Throughput: one request per cycle while slaves ack immediately (count oscillates 1/1).
- Simultaneous accept and pop with count == 1: count stays 1, pointers both advance.
- Ordering: strictly in order. Head-of-line blocking across slaves is intended. Tag order equals read acceptance order.
- Count width: 2 bits, values 0..2. Pointers: 1 bit, wrap 1 -> 0.
- Reset mid-operation: pending entries are discarded and sK_req_o falls the cycle after reset is sampled. The sequencer tag FIFO shares rst_i, so no stale tags remain.

Test Plan:
- Read, addr 0x4000_0010, tag FIFO not full -> m_ack_o = 1 and tag_fifo_wrreq_o = 1 with wdata = 1 in the same cycle. Next cycle s1_req_o = 1, s1_addr_bo = 0x4000_0010, s1_we_o = 0. s1_ack_i asserted 3 cycles later -> s1_req_o = 0 on the following cycle.
- Write, addr 0xC000_0004, wdata 0xDEADBEEF -> m_ack_o = 1, tag_fifo_wrreq_o = 0. Next cycle s3_req_o = 1, s3_we_o = 1, s3_wdata_bo = 0xDEADBEEF.
- tag_fifo_full_i = 1: read to 0x0 -> m_ack_o = 0, no push. Switch to a write -> accepted. Deassert full -> read accepted, tag 0 pushed.
- Reads to 0x0, 0x8000_0000, 0x4000_0000 back-to-back, no slave ack -> first two accepted (tags 0, 2), third stalled. Ack s0 -> s2_req_o next cycle; third is accepted only once count < 2, tag 1 pushed.
- count == 1, s0 acking while a new write to 0x4000_0000 arrives -> accept and pop in the same cycle. Next cycle s1_req_o = 1, count = 1.
- Two entries pending, rst_i pulsed for 1 cycle -> all sK_req_o = 0 afterwards, m_ack_o = 1 for the next request, no ghost issue.
